// File: rtl/control_wb.sv
// Writeback control: IR3/flags, branch resolve, regfile write, flush/halt; outputs registered-state only.
// CONTROL_WB_RETIRE_CNT_EN adds a 16-bit wrapping retire_count output.
module control_wb #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       en_exec,
   input  logic [7:0] ir2_in,
   input  logic       ir3_load,
   input  logic       flag_write,
   input  logic       alu_z,
   input  logic       alu_n,
   output logic       reg_write,
   output logic [1:0] reg_w_sel,
   output logic       reg_in_sel,
   output logic       pc_branch_load,
   output logic       flush,
   output logic       halt,
   output logic       flag_z,
   output logic       flag_n
`ifdef CONTROL_WB_RETIRE_CNT_EN
   ,
   output logic [15:0] retire_count
`endif
);

   typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_e;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] IR_NOP     = 8'h0A;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] ir3_q, ir3_d;
   logic       ir3_vld_q, ir3_vld_d;
   logic       flag_z_q, flag_z_d;
   logic       flag_n_q, flag_n_d;

   logic       run;
   logic       active;
   logic       br_taken;
   logic [3:0] op;

   assign run    = (state_q == S_RUN);
   assign active = ir3_vld_q && run;
   assign op     = ir3_q[3:0];

   // IR3[5:4] carry no meaning at writeback.
   logic unused_ir3_bits;
   assign unused_ir3_bits = ^ir3_q[5:4];

   always_comb begin
      br_taken = 1'b0;
      if (active) begin
         case (op)
            4'd5:    br_taken = flag_z_q;
            4'd9:    br_taken = !flag_z_q;
            4'd13:   br_taken = !flag_n_q;
            default: br_taken = 1'b0;
         endcase
      end
   end

   always_comb begin
      reg_write  = 1'b0;
      reg_w_sel  = 2'd0;
      reg_in_sel = 1'b0;
      if (active) begin
         if (ir3_q[2:0] == 3'd7) begin
            reg_write = 1'b1;
            reg_w_sel = 2'd1;
         end else if (ir3_q[2:0] == 3'd3 || op == 4'd4 || op == 4'd6 || op == 4'd8) begin
            reg_write = 1'b1;
            reg_w_sel = ir3_q[7:6];
         end else if (op == 4'd0) begin
            reg_write  = 1'b1;
            reg_in_sel = 1'b1;
            reg_w_sel  = ir3_q[7:6];
         end
      end
   end

   assign pc_branch_load = br_taken;
   assign flush          = (state_q == S_FLUSH);
   assign halt           = (state_q == S_HALT);
   assign flag_z         = flag_z_q;
   assign flag_n         = flag_n_q;

   always_comb begin
      ir3_d     = ir3_q;
      ir3_vld_d = 1'b0;
      flag_z_d  = flag_z_q;
      flag_n_d  = flag_n_q;
      if (run && en_exec && ir3_load) begin
         ir3_d     = ir2_in;
         ir3_vld_d = 1'b1;
      end
      if (run && en_exec && flag_write) begin
         flag_z_d = alu_z;
         flag_n_d = alu_n;
      end
   end

   // A taken branch outranks a STOP arriving in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RUN: begin
            if (br_taken) begin
               state_d = S_FLUSH;
               cnt_d   = FLUSH_INIT;
            end else if (en_exec && ir2_in[3:0] == 4'd1) begin
               state_d = S_HALT;
            end
         end
         S_FLUSH: begin
            if (cnt_q == 3'd0) state_d = S_RUN;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_RUN;
         cnt_q     <= 3'd0;
         ir3_q     <= IR_NOP;
         ir3_vld_q <= 1'b0;
         flag_z_q  <= 1'b0;
         flag_n_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ir3_q     <= ir3_d;
         ir3_vld_q <= ir3_vld_d;
         flag_z_q  <= flag_z_d;
         flag_n_q  <= flag_n_d;
      end
   end

`ifdef CONTROL_WB_RETIRE_CNT_EN
   logic [15:0] retire_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)      retire_q <= 16'd0;
      else if (active) retire_q <= retire_q + 16'd1;
   end

   assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_control_wb.sv
// Bench for control_wb: default instance (FLUSH_CYCLES=2) plus a FLUSH_CYCLES=4 instance on shared inputs.
module tb_control_wb;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       en_exec = 1'b0;
   logic [7:0] ir2_in = 8'h0A;
   logic       ir3_load = 1'b0;
   logic       flag_write = 1'b0;
   logic       alu_z = 1'b0;
   logic       alu_n = 1'b0;

   logic       reg_write, reg_in_sel, pc_branch_load, flush, halt, flag_z, flag_n;
   logic [1:0] reg_w_sel;
   logic       unused_w4, unused_is4, unused_pbl4, unused_h4, unused_z4, unused_n4, flush4;
   logic [1:0] unused_sel4;
`ifdef CONTROL_WB_RETIRE_CNT_EN
   logic [15:0] retire_count, unused_retire4;
`endif

   always #5 clock = ~clock;

   control_wb dut (
      .clock(clock), .reset(reset), .en_exec(en_exec), .ir2_in(ir2_in),
      .ir3_load(ir3_load), .flag_write(flag_write), .alu_z(alu_z), .alu_n(alu_n),
      .reg_write(reg_write), .reg_w_sel(reg_w_sel), .reg_in_sel(reg_in_sel),
      .pc_branch_load(pc_branch_load), .flush(flush), .halt(halt),
      .flag_z(flag_z), .flag_n(flag_n)
`ifdef CONTROL_WB_RETIRE_CNT_EN
      , .retire_count(retire_count)
`endif
   );

   control_wb #(.FLUSH_CYCLES(4)) dut4 (
      .clock(clock), .reset(reset), .en_exec(en_exec), .ir2_in(ir2_in),
      .ir3_load(ir3_load), .flag_write(flag_write), .alu_z(alu_z), .alu_n(alu_n),
      .reg_write(unused_w4), .reg_w_sel(unused_sel4), .reg_in_sel(unused_is4),
      .pc_branch_load(unused_pbl4), .flush(flush4), .halt(unused_h4),
      .flag_z(unused_z4), .flag_n(unused_n4)
`ifdef CONTROL_WB_RETIRE_CNT_EN
      , .retire_count(unused_retire4)
`endif
   );

   typedef struct packed {
      logic       e;
      logic [7:0] ir;
      logic       ld;
      logic       fw;
      logic       z;
      logic       n;
   } stim_t;

   int checks = 0;
   int errors = 0;

   // {flush4, reg_write, reg_w_sel, reg_in_sel, pc_branch_load, flush, halt, flag_z, flag_n}
   logic [9:0] obs;
   assign obs = {flush4, reg_write, reg_w_sel, reg_in_sel, pc_branch_load, flush, halt, flag_z, flag_n};

   logic [9:0] expq[$];

   localparam logic [7:0] ADD   = 8'b10_01_0100;
   localparam logic [7:0] ORI   = 8'b10101_111;
   localparam logic [7:0] LOAD  = 8'b11_00_0000;
   localparam logic [7:0] SHIFT = 8'b01_00_0011;
   localparam logic [7:0] SUB   = 8'b01_10_0110;
   localparam logic [7:0] BZ    = 8'h05;
   localparam logic [7:0] BNZ   = 8'h09;
   localparam logic [7:0] BPZ   = 8'h0D;
   localparam logic [7:0] STOP  = 8'h01;
   localparam logic [7:0] NOP   = 8'h0A;

   function automatic stim_t s(bit e, logic [7:0] ir, bit ld, bit fw, bit z, bit n);
      return '{e: e, ir: ir, ld: ld, fw: fw, z: z, n: n};
   endfunction

   function automatic logic [9:0] ev(bit f4, bit w, bit [1:0] sel, bit isel, bit pbl,
                                     bit fl, bit h, bit z, bit n);
      return {f4, w, sel, isel, pbl, fl, h, z, n};
   endfunction

   task automatic drive(input stim_t st);
      en_exec    = st.e;
      ir2_in     = st.ir;
      ir3_load   = st.ld;
      flag_write = st.fw;
      alu_z      = st.z;
      alu_n      = st.n;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [9:0] e;
      drive(s(0, NOP, 0, 0, 0, 0));
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs !== 10'd0) begin errors++; $display("FAIL reset_initial: got %b expected %b", obs, 10'd0); end
      @(negedge clock) reset = 1'b1;
      tick();
      drive(s(1, ADD, 1, 1, 1, 1));
      expq.push_back(ev(0, 1, 2'd2, 0, 0, 0, 0, 1, 1));
      tick();
      e = expq.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_pre_state: got %b expected %b", obs, e); end
      drive(s(0, NOP, 0, 0, 0, 0));
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs !== 10'd0) begin errors++; $display("FAIL reset_midcycle: got %b expected %b", obs, 10'd0); end
      checks++;
      if (dut.ir3_q !== 8'h0A) begin errors++; $display("FAIL reset_ir3: got %h expected 0a", dut.ir3_q); end
      @(negedge clock) reset = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      stim_t st[$];
      logic [9:0] ex[$];
      logic [9:0] e;
      st.push_back(s(1, ADD,   1, 1, 1, 0)); ex.push_back(ev(0, 1, 2'd2, 0, 0, 0, 0, 1, 0));
      st.push_back(s(1, ORI,   1, 1, 0, 1)); ex.push_back(ev(0, 1, 2'd1, 0, 0, 0, 0, 0, 1));
      st.push_back(s(1, LOAD,  1, 0, 0, 0)); ex.push_back(ev(0, 1, 2'd3, 1, 0, 0, 0, 0, 1));
      st.push_back(s(1, SHIFT, 1, 0, 0, 0)); ex.push_back(ev(0, 1, 2'd1, 0, 0, 0, 0, 0, 1));
      st.push_back(s(0, ADD,   1, 1, 1, 1)); ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      st.push_back(s(1, SUB,   1, 0, 0, 0)); ex.push_back(ev(0, 1, 2'd1, 0, 0, 0, 0, 0, 1));
      st.push_back(s(1, NOP,   1, 0, 0, 0)); ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      st.push_back(s(1, ADD,   0, 0, 0, 0)); ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         expq.push_back(ex[i]);
         tick();
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL alu step %0d: got %b expected %b", i, obs, e); end
      end
   endtask

   task automatic test_branch();
      stim_t st[$];
      logic [9:0] ex[$];
      logic [9:0] e;
      stim_t idle;
      idle = s(0, NOP, 0, 0, 0, 0);
      // BZ taken, flag_write during flush ignored
      st.push_back(s(1, ADD, 1, 1, 1, 0)); ex.push_back(ev(0, 1, 2'd2, 0, 0, 0, 0, 1, 0));
      st.push_back(s(1, BZ,  1, 0, 0, 0)); ex.push_back(ev(0, 0, 2'd0, 0, 1, 0, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 1, 0, 1, 0));
      st.push_back(s(1, ADD, 1, 1, 0, 1)); ex.push_back(ev(1, 0, 2'd0, 0, 0, 1, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      // BNZ with Z=1: not taken
      st.push_back(s(1, BNZ, 1, 0, 0, 0)); ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      // BPZ with N=0: taken
      st.push_back(s(1, BPZ, 1, 0, 0, 0)); ex.push_back(ev(0, 0, 2'd0, 0, 1, 0, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 1, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 1, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      st.push_back(idle);                  ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      // Z=0, N=1: BZ and BPZ not taken, BNZ taken
      st.push_back(s(1, ADD, 1, 1, 0, 1)); ex.push_back(ev(0, 1, 2'd2, 0, 0, 0, 0, 0, 1));
      st.push_back(s(1, BZ,  1, 0, 0, 0)); ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      st.push_back(s(1, BPZ, 1, 0, 0, 0)); ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      st.push_back(s(1, BNZ, 1, 0, 0, 0)); ex.push_back(ev(0, 0, 2'd0, 0, 1, 0, 0, 0, 1));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 1, 0, 0, 1));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 1, 0, 0, 1));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      st.push_back(idle);                  ex.push_back(ev(1, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      st.push_back(idle);                  ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         expq.push_back(ex[i]);
         tick();
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL branch step %0d: got %b expected %b", i, obs, e); end
      end
   endtask

   task automatic test_stop();
      logic [9:0] e;
      drive(s(1, ADD, 1, 1, 0, 1));
      expq.push_back(ev(0, 1, 2'd2, 0, 0, 0, 0, 0, 1));
      tick();
      e = expq.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL stop_setup: got %b expected %b", obs, e); end
      drive(s(1, STOP, 0, 0, 0, 0));
      for (int i = 0; i < 21; i++) begin
         expq.push_back(ev(0, 0, 2'd0, 0, 0, 0, 1, 0, 1));
         tick();
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL stop_halt cycle %0d: got %b expected %b", i, obs, e); end
         drive(stim_t'($urandom));
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs !== 10'd0) begin errors++; $display("FAIL stop_reset: got %b expected %b", obs, 10'd0); end
      drive(s(0, NOP, 0, 0, 0, 0));
      @(negedge clock) reset = 1'b1;
      tick();
      checks++;
      if (obs !== 10'd0) begin errors++; $display("FAIL stop_after_reset: got %b expected %b", obs, 10'd0); end
   endtask

   task automatic test_branch_stop();
      stim_t st[$];
      logic [9:0] ex[$];
      logic [9:0] e;
      stim_t idle;
      idle = s(0, NOP, 0, 0, 0, 0);
      st.push_back(s(1, ADD,  1, 1, 1, 0)); ex.push_back(ev(0, 1, 2'd2, 0, 0, 0, 0, 1, 0));
      st.push_back(s(1, BZ,   1, 0, 0, 0)); ex.push_back(ev(0, 0, 2'd0, 0, 1, 0, 0, 1, 0));
      st.push_back(s(1, STOP, 0, 0, 0, 0)); ex.push_back(ev(1, 0, 2'd0, 0, 0, 1, 0, 1, 0));
      st.push_back(idle);                   ex.push_back(ev(1, 0, 2'd0, 0, 0, 1, 0, 1, 0));
      st.push_back(idle);                   ex.push_back(ev(1, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      st.push_back(idle);                   ex.push_back(ev(1, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      st.push_back(idle);                   ex.push_back(ev(0, 0, 2'd0, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         expq.push_back(ex[i]);
         tick();
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL branch_stop step %0d: got %b expected %b", i, obs, e); end
      end
   endtask

`ifdef CONTROL_WB_RETIRE_CNT_EN
   task automatic test_retire();
      logic [15:0] rq[$];
      logic [15:0] e;
      logic [15:0] exp_cnt[5];
      stim_t add_s, idle;
      add_s = s(1, ADD, 1, 0, 0, 0);
      idle  = s(0, NOP, 0, 0, 0, 0);
      exp_cnt = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3};
      #2 reset = 1'b0;
      @(negedge clock) reset = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(i < 3 ? add_s : idle);
         rq.push_back(exp_cnt[i]);
         tick();
         e = rq.pop_front();
         checks++;
         if (retire_count !== e) begin errors++; $display("FAIL retire step %0d: got %0d expected %0d", i, retire_count, e); end
      end
      drive(add_s);
      repeat (65532) tick();
      drive(idle);
      rq.push_back(16'hFFFF);
      tick();
      e = rq.pop_front();
      checks++;
      if (retire_count !== e) begin errors++; $display("FAIL retire_max: got %0d expected %0d", retire_count, e); end
      drive(add_s);
      rq.push_back(16'hFFFF);
      tick();
      e = rq.pop_front();
      checks++;
      if (retire_count !== e) begin errors++; $display("FAIL retire_hold: got %0d expected %0d", retire_count, e); end
      drive(idle);
      rq.push_back(16'd0);
      tick();
      e = rq.pop_front();
      checks++;
      if (retire_count !== e) begin errors++; $display("FAIL retire_wrap: got %0d expected %0d", retire_count, e); end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_stop();
      test_branch_stop();
`ifdef CONTROL_WB_RETIRE_CNT_EN
      test_retire();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_wb.md
Name: control_wb

Overview:
- Writeback-stage controller, directly downstream of the execute-stage control.
- Owns IR3, the stage-3 instruction register loaded when execute asserts ir3_load, and its valid bit.
- Owns the Z/N flag registers, resolves conditional branches, and generates register-file write controls.
- Sequences pipeline flush after a taken branch and halts the pipeline on STOP.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch; legal range 1..7.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
en_exec  input  1  execute stage holds a valid instruction this cycle
ir2_in  input  8  instruction in execute stage
ir3_load  input  1  from execute control; capture ir2_in into IR3
flag_write  input  1  from execute control; update Z/N registers
alu_z  input  1  ALU result zero, from execute
alu_n  input  1  ALU result negative, from execute
reg_write  output  1  register-file write enable, stage 3
reg_w_sel  output  2  destination register number
reg_in_sel  output  1  0 = ALUout, 1 = MDR
pc_branch_load  output  1  load PC from ALUout (taken branch)
flush  output  1  squash stages 1-2
halt  output  1  processor stopped
flag_z  output  1  Z flag register
flag_n  output  1  N flag register

Behaviour:
- Reset (reset low, asynchronous):
  - IR3 = 8'h0A (NOP); ir3_valid = 0; flag_z = 0; flag_n = 0.
  - State = RUN; flush counter = 0.
  - All outputs 0.
- Capture: rising edge with ir3_load=1, en_exec=1 and state RUN:
  - IR3 <= ir2_in; ir3_valid <= 1.
  - Any other case: ir3_valid <= 0.
- Flags: at the same edge, if flag_write=1 and en_exec=1 and state RUN, flag_z <= alu_z and flag_n <= alu_n.
  - A branch in IR3 therefore tests flags of the last flag-writing instruction ahead of it, never its own.
- Decode of IR3 (combinational, gated by ir3_valid and state RUN):
  - IR3[2:0]=3 (SHIFT), or opcode 4/6/8 (ADD/SUB/NAND): reg_write=1, reg_in_sel=0, reg_w_sel=IR3[7:6].
  - IR3[2:0]=7 (ORI): reg_write=1, reg_in_sel=0, reg_w_sel=2'd1.
  - Opcode 0 (LOAD): reg_write=1, reg_in_sel=1, reg_w_sel=IR3[7:6].
  - BZ(5): taken if flag_z=1. BNZ(9): taken if flag_z=0. BPZ(13): taken if flag_n=0.
  - Taken branch: pc_branch_load=1 for that one cycle.
  - All other opcodes: no write, no branch.
  - Outputs not driven by a rule above are 0.
- State machine:
  - RUN:
    - Taken branch -> FLUSH; counter <= FLUSH_CYCLES-1.
    - Else en_exec=1 and ir2_in[3:0]=1 (STOP) -> HALT.
    - A taken branch and STOP in the same cycle go to FLUSH; the STOP is squashed.
  - FLUSH:
    - flush=1; counter decrements each cycle.
    - Counter = 0 -> RUN.
    - No captures, flag updates or writes occur during FLUSH.
    - flush is asserted for exactly FLUSH_CYCLES cycles, starting the cycle after pc_branch_load.
  - HALT:
    - halt=1; all write/branch outputs 0; ignores all inputs.
    - Left only by reset.
- Reset asserted mid-FLUSH or in HALT returns to RUN immediately, with all registers at reset values.
- Outputs are combinational from registered state only; no input-to-output combinational paths except none (all outputs are functions of IR3, ir3_valid, flags, state).

Optional Feature:
- Macro: CONTROL_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_count [15:0], reset to 0.
  - Increments each cycle in which ir3_valid=1 and state RUN (one retired instruction).
  - Wraps from 16'hFFFF to 0.
  - Does not count during FLUSH or HALT.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: reset low mid-cycle -> all outputs 0 immediately; IR3=8'h0A; state RUN.
- ALU ops:
  - ir2_in=8'b10_01_0100 (ADD R2,R1) with ir3_load, en_exec, flag_write, alu_z=1 -> next cycle reg_write=1, reg_w_sel=2, reg_in_sel=0, flag_z=1.
  - ORI 8'b10101_111 -> reg_w_sel=1.
  - LOAD 8'b11_00_0000 -> reg_in_sel=1, reg_w_sel=3.
- Branches:
  - flag_z=1, then BZ (8'h05) loaded -> pc_branch_load=1 one cycle, then flush=1 for exactly 2 cycles, no reg_write.
  - Same with BNZ -> no branch, no flush.
  - FLUSH_CYCLES=4 -> flush lasts 4 cycles.
- Flags in flush: flag_write pulse with alu_z=0 during FLUSH -> flag_z unchanged.
- Stop:
  - en_exec=1, ir2_in=8'h01 -> halt=1 next cycle and stays high for 20 cycles of random inputs; reset low clears it.
  - Same-cycle taken branch + STOP -> FLUSH, halt stays 0.
- Retire counter (macro defined):
  - 3 ADDs -> retire_count=3.
  - Preload via 65535 retires -> next retire wraps to 0.
